// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous data-memory port (one-cycle read latency)
// between the processor load/store path (A) and the loader/debug path (B).
// B may lock the port for bursts. After LOCK_MAX consecutive locked grants with A
// waiting, A gets exactly one slot.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When defined, unlocked contention
// is round robin. Otherwise it is fixed priority to A.
module data_mem_arbiter #(
   parameter int unsigned ADDR_SIZE = 18,
   parameter int unsigned WORD_SIZE = 18,
   parameter int unsigned LOCK_MAX  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_a,
   input  logic                 we_a,
   input  logic [ADDR_SIZE-1:0] addr_a,
   input  logic [WORD_SIZE-1:0] wdata_a,
   input  logic                 req_b,
   input  logic                 we_b,
   input  logic [ADDR_SIZE-1:0] addr_b,
   input  logic [WORD_SIZE-1:0] wdata_b,
   input  logic                 lock_b,
   output logic                 gnt_a,
   output logic                 gnt_b,
   output logic                 rvalid_a,
   output logic                 rvalid_b,
   output logic [WORD_SIZE-1:0] rdata_a,
   output logic [WORD_SIZE-1:0] rdata_b,
   output logic                 memory_write_enable,
   output logic [ADDR_SIZE-1:0] memory_addr,
   output logic [WORD_SIZE-1:0] memory_in,
   input  logic [WORD_SIZE-1:0] memory_out
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   logic             last_q, last_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             rd_own_a_q, rd_own_b_q;
   logic             lock_hold;

   // Grant decision: single requester wins, an unexhausted lock favours B, else mode rule.
   always_comb begin
      gnt_a     = 1'b0;
      gnt_b     = 1'b0;
      lock_hold = locked_q && (lock_cnt_q < LOCK_LIMIT);
      if (reset) begin
         if (req_a && !req_b) begin
            gnt_a = 1'b1;
         end else if (!req_a && req_b) begin
            gnt_b = 1'b1;
         end else if (req_a && req_b) begin
            if (lock_hold) begin
               gnt_b = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            end else if (last_q == PORT_A) begin
               gnt_b = 1'b1;
            end else begin
               gnt_a = 1'b1;
            end
`else
            end else begin
               gnt_a = 1'b1;
            end
`endif
         end
      end
   end

   // Next-state for last-granted port, lock flag and lock counter.
   always_comb begin
      last_d     = last_q;
      locked_d   = locked_q;
      lock_cnt_d = lock_cnt_q;
      if (gnt_a) begin
         last_d     = PORT_A;
         lock_cnt_d = '0;
         // The single A slot forced by an exhausted lock does not end B's burst:
         // ownership resumes if B still requests with lock_b held.
         locked_d   = locked_q && (lock_cnt_q == LOCK_LIMIT) && req_b && lock_b;
      end else if (gnt_b) begin
         last_d   = PORT_B;
         locked_d = lock_b;
         if (!lock_b) begin
            lock_cnt_d = '0;
         end else if (req_a && (lock_cnt_q < LOCK_LIMIT)) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
         end
      end else begin
         // No grant while out of reset means B is not requesting.
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end
   end

   // Memory port mux: winner's access, all-zero when idle.
   always_comb begin
      memory_write_enable = 1'b0;
      memory_addr         = '0;
      memory_in           = '0;
      if (gnt_a) begin
         memory_write_enable = we_a;
         memory_addr         = addr_a;
         memory_in           = wdata_a;
      end else if (gnt_b) begin
         memory_write_enable = we_b;
         memory_addr         = addr_b;
         memory_in           = wdata_b;
      end
   end

   // Read return: data is shared, valid is per-owner and suppressed during reset.
   always_comb begin
      rdata_a  = memory_out;
      rdata_b  = memory_out;
      rvalid_a = rd_own_a_q && reset;
      rvalid_b = rd_own_b_q && reset;
   end

   // State registers with synchronous active-low reset; last resets to B so A goes first.
   always_ff @(posedge clock) begin
      if (!reset) begin
         last_q     <= PORT_B;
         locked_q   <= 1'b0;
         lock_cnt_q <= '0;
         rd_own_a_q <= 1'b0;
         rd_own_b_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         locked_q   <= locked_d;
         lock_cnt_q <= lock_cnt_d;
         rd_own_a_q <= gnt_a && !we_a;
         rd_own_b_q <= gnt_b && !we_b;
      end
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single synchronous data-memory port (18-bit address, 18-bit word, one-cycle read latency) between two requesters. Port A is the processor load/store path. Port B is the program loader/debug path. The block issues at most one access per cycle, sends read data back to the requester that issued the read, and supports a bounded lock that lets B perform bursts without interruption. It sits between the processor's memory interface and the data RAM.

## Interface
- ADDR_SIZE, 18, address width
- WORD_SIZE, 18, data word width
- LOCK_MAX, 16, maximum consecutive locked grants to B while A is waiting (≥1)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_a / req_b  in  1  access request, held until granted
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_SIZE  access address
- wdata_a / wdata_b  in  WORD_SIZE  write data
- lock_b  in  1  B asks to keep ownership on its next request
- gnt_a / gnt_b  out  1  combinational grant, same cycle as request
- rvalid_a / rvalid_b  out  1  read data valid for that port
- rdata_a / rdata_b  out  WORD_SIZE  read data, wired to mem_out
- memory_write_enable  out  1  RAM write strobe
- memory_addr  out  ADDR_SIZE  RAM address
- memory_in  out  WORD_SIZE  RAM write data
- memory_out  in  WORD_SIZE  RAM read data, valid one cycle after address

## Operation
- Registers:
  - `last` (1 bit): last port granted.
  - `locked` (1 bit): B granted last cycle with lock_b=1.
  - `lock_cnt` (clog2(LOCK_MAX+1) bits).
  - `rd_own_a` / `rd_own_b`: read-return pipeline stage.
- Grant decision, combinational:
  - Only one port requests: that port wins.
  - Both request, `locked`=1 and lock_cnt<LOCK_MAX: B wins.
  - Both request, otherwise: arbitration mode applies (see Configuration).
- Lock counter:
  - Increments on each locked B grant while req_a=1.
  - Clears on any A grant or when `locked` falls.
  - When lock_cnt=LOCK_MAX, A gets exactly one slot. The lock then resumes if lock_b is still 1.
- `locked` update:
  - Set to gnt_b & lock_b.
  - Cleared by an A grant, by req_b=0, or by lock_b=0.
- Memory drive:
  - Winner's addr/wdata are muxed to memory_addr/memory_in.
  - memory_write_enable = winner's we.
  - No winner: memory_write_enable=0, memory_addr=0, memory_in=0.
- Read return: rd_own_x <= gnt_x & ~we_x. rvalid_x = rd_own_x.
- Writes produce no rvalid.
- rdata_a = rdata_b = memory_out at all times. Only rvalid qualifies the data.

## Timing
- Cycle N with req_x=1 and gnt_x=1: access is accepted. A write commits at the rising edge that ends cycle N.
- Read accepted in cycle N: rvalid_x=1 and rdata_x valid in cycle N+1 only.
- Throughput is one access per cycle. Back-to-back reads from one port give rvalid on consecutive cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Deasserting req before gnt is allowed. It cancels the request.
- A write to address X in cycle N followed by a read of X in cycle N+1 returns the new data, because RAM ordering is preserved.
- While reset=0:
  - gnt_a=gnt_b=0, memory_write_enable=0, rvalid_a=rvalid_b=0.
  - `last`=B, so A is preferred first. locked=0, lock_cnt=0.
- Reset asserted mid-operation: a read accepted in the cycle before reset gets no rvalid, and its pipeline stage is cleared.
- Release: the first cycle with reset=1 can grant.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Unlocked contention goes to the port not equal to `last`.
  - `last` updates on every grant.
- Not defined:
  - Fixed priority, A always wins unlocked contention. `last` is still maintained but ignored.
  - Lock and LOCK_MAX behaviour are identical in both builds.

## Test plan
- Reset: hold reset=0 for 3 cycles with req_a=req_b=1 -> gnt=0, memory_write_enable=0, rvalid=0. First cycle after release -> gnt_a=1.
- Single port: A writes 0x2A5A5 to 0x00010, then reads 0x00010 next cycle -> rvalid_a=1 with rdata_a=0x2A5A5 one cycle after the read grant, and rvalid_b stays 0.
- Contention, round robin: both request reads continuously, addresses 0x1/0x2 -> grants alternate A,B,A,B. Without the macro -> A granted every cycle and B never granted.
- Lock: B locked burst of 40 cycles, A requesting throughout, LOCK_MAX=16 -> 16 B grants, 1 A grant, 16 B, 1 A, remainder B. lock_cnt never exceeds 16.
- Lock release: B drops lock_b with both requesting -> next contention goes to A (round robin with last=B).
- Reset mid-read: A read granted in cycle N, reset=0 in N+1 -> rvalid_a=0 in N+1 and N+2.
